// File: rtl/conv1_tile_writeback.sv
// Purpose : buffers one ROWS x COLS accumulator tile, then requantizes and writes it out column-major to NCHW memory.
// Latency : first write the cycle after the last row beat; ROWS*COLS drain cycles with wr_ready high; tile_done one cycle later.
// Backpressure: row_ready is low for the whole drain; a valid write holds addr/data until wr_ready, out-of-range positions never stall.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cfg_shift, cfg_relu      requant shift / ReLU enable, latched on beat 0 of a tile
//   row_valid/row_ready      accumulator row handshake; row_data element j -> column n_base+j
//   row_m_base, row_n_base   tile origin, latched on beat 0 of a tile
//   wr_en/wr_ready           write handshake; wr_addr = n*M_TOTAL+m, wr_data = requantized element
//   tile_done                one-cycle pulse after the final drain step
module conv1_tile_writeback #(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int M_TOTAL  = 3136,
    parameter int N_TOTAL  = 64,
    parameter int DATA_W_P = 8,
    parameter int ACC_W_P  = 32,
    parameter int AW       = $clog2(M_TOTAL * N_TOTAL)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [4:0]                     cfg_shift,
    input  logic                           cfg_relu,
    input  logic                           row_valid,
    output logic                           row_ready,
    input  logic [COLS-1:0][ACC_W_P-1:0]   row_data,
    input  logic [11:0]                    row_m_base,
    input  logic [6:0]                     row_n_base,
    output logic                           wr_en,
    input  logic                           wr_ready,
    output logic [AW-1:0]                  wr_addr,
    output logic signed [DATA_W_P-1:0]     wr_data,
    output logic                           tile_done
);

    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ACC1 = ACC_W_P + 1;

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    localparam logic signed [ACC1-1:0] ONE     = ACC1'(1);
    localparam logic signed [ACC1-1:0] SAT_MAX = ACC1'((1 <<< (DATA_W_P - 1)) - 1);
    localparam logic signed [ACC1-1:0] SAT_MIN = ACC1'(-(1 <<< (DATA_W_P - 1)));

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] beat_q, beat_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [11:0]   m_base_q, m_base_d;
    logic [6:0]    n_base_q, n_base_d;
    logic [4:0]    shift_q, shift_d;
    logic          relu_q, relu_d;
    logic          done_q, done_d;
    logic          load_row;

    logic [COLS-1:0][ACC_W_P-1:0] tile_q [ROWS];

    // Position decode for the current drain step.
    logic [31:0] m_w, n_w;
    logic        pos_valid;
    logic        step_adv;

    assign m_w       = 32'(m_base_q) + 32'(row_q);
    assign n_w       = 32'(n_base_q) + 32'(col_q);
    assign pos_valid = (m_w < 32'(M_TOTAL)) && (n_w < 32'(N_TOTAL));
    // Skipped positions cost one cycle each so drain time is fixed per tile.
    assign step_adv  = !pos_valid || wr_ready;

    // row_ready depends on state only, keeping wr_ready off the row path.
    assign row_ready = (state_q == COLLECT);
    assign wr_en     = (state_q == DRAIN) && pos_valid;
    assign wr_addr   = wr_en ? AW'(n_w * 32'(M_TOTAL) + m_w) : '0;
    assign tile_done = done_q;

    // Requantize the selected element; one extra bit keeps the rounding add from overflowing.
    logic [ACC_W_P-1:0]       acc;
    logic signed [ACC1-1:0]   ext, bias, rnd, shr, rel;
    logic [DATA_W_P-1:0]      q;

    always_comb begin
        acc  = tile_q[row_q][col_q];
        ext  = {acc[ACC_W_P-1], acc};
        bias = '0;
        if (shift_q != 5'd0) begin
            bias = ONE <<< (shift_q - 5'd1);
        end
        rnd = ext + bias;
        shr = rnd >>> shift_q;
        rel = shr;
        if (relu_q && shr[ACC1-1]) begin
            rel = '0;
        end
        if (rel > SAT_MAX) begin
            q = SAT_MAX[DATA_W_P-1:0];
        end else if (rel < SAT_MIN) begin
            q = SAT_MIN[DATA_W_P-1:0];
        end else begin
            q = rel[DATA_W_P-1:0];
        end
    end

    assign wr_data = wr_en ? $signed(q) : '0;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        row_d    = row_q;
        col_d    = col_q;
        m_base_d = m_base_q;
        n_base_d = n_base_q;
        shift_d  = shift_q;
        relu_d   = relu_q;
        done_d   = 1'b0;
        load_row = 1'b0;
        case (state_q)
            COLLECT: begin
                if (row_valid) begin
                    load_row = 1'b1;
                    if (beat_q == '0) begin
                        m_base_d = row_m_base;
                        n_base_d = row_n_base;
                        shift_d  = cfg_shift;
                        relu_d   = cfg_relu;
                    end
                    if (beat_q == LAST_ROW) begin
                        beat_d  = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        beat_d = beat_q + RW'(1);
                    end
                end
            end
            DRAIN: begin
                if (step_adv) begin
                    if (row_q == LAST_ROW) begin
                        row_d = '0;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            state_d = COLLECT;
                            done_d  = 1'b1;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            beat_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            m_base_q <= '0;
            n_base_q <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            row_q    <= row_d;
            col_q    <= col_d;
            m_base_q <= m_base_d;
            n_base_q <= n_base_d;
            shift_q  <= shift_d;
            relu_q   <= relu_d;
            done_q   <= done_d;
        end
    end

    // Tile storage is fully rewritten before every drain, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_row) begin
            tile_q[beat_q] <= row_data;
        end
    end

endmodule

// File: tb/tb_conv1_tile_writeback.sv
module tb_conv1_tile_writeback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [4:0]          cfg_shift;
    logic                cfg_relu;
    logic                rv, sel_b;
    logic                row_valid, row_valid_b;
    logic                row_ready, row_ready_b;
    logic [15:0][31:0]   row_data;
    logic [11:0]         row_m_base;
    logic [6:0]          row_n_base;
    logic                wr_en, wr_en_b, wr_ready;
    logic [17:0]         wr_addr;
    logic [10:0]         wr_addr_b;
    logic signed [7:0]   wr_data, wr_data_b;
    logic                tile_done, tile_done_b;

    assign row_valid   = rv & ~sel_b;
    assign row_valid_b = rv & sel_b;

    conv1_tile_writeback dut (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_m_base(row_m_base), .row_n_base(row_n_base),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .tile_done(tile_done)
    );

    conv1_tile_writeback #(.M_TOTAL(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .row_valid(row_valid_b), .row_ready(row_ready_b), .row_data(row_data),
        .row_m_base(row_m_base), .row_n_base(row_n_base),
        .wr_en(wr_en_b), .wr_ready(wr_ready), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .tile_done(tile_done_b)
    );

    logic               o_en, o_rdy, o_done;
    logic [31:0]        o_addr;
    logic signed [7:0]  o_data;
    assign o_en   = sel_b ? wr_en_b : wr_en;
    assign o_rdy  = sel_b ? row_ready_b : row_ready;
    assign o_done = sel_b ? tile_done_b : tile_done;
    assign o_addr = sel_b ? 32'(wr_addr_b) : 32'(wr_addr);
    assign o_data = sel_b ? wr_data_b : wr_data;

    int n_checks, n_errors;
    int tile_v [16][16];
    int obs_addr [256];
    int obs_data [256];
    int g_mb, g_nb, g_sh;
    bit g_rl;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int requant(input int acc, input int s, input bit relu);
        longint v;
        v = acc;
        if (s > 0) v = (v + (longint'(1) <<< (s - 1))) >>> s;
        if (relu && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v);
    endfunction

    task automatic fill_identity();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                tile_v[r][c] = r + 16 * c;
    endtask

    // Beats after the first carry junk config to prove only beat 0 is latched.
    task automatic drive_row(input int r);
        rv = 1'b1;
        for (int j = 0; j < 16; j++) row_data[j] = tile_v[r][j];
        if (r == 0) begin
            row_m_base = 12'(g_mb); row_n_base = 7'(g_nb);
            cfg_shift  = 5'(g_sh);  cfg_relu   = g_rl;
        end else begin
            row_m_base = 12'hABC; row_n_base = 7'h55;
            cfg_shift  = 5'd9;    cfg_relu   = ~g_rl;
        end
    endtask

    task automatic send_tile(input int first);
        for (int r = first; r < 16; r++) begin
            drive_row(r);
            @(posedge clk); #1;
        end
        rv = 1'b0;
    endtask

    task automatic drain(input int m_tot, input int mb, input int nb, input int sh, input bit rl,
                         input bit bp, input int stop_after,
                         output int nwr, output int done_at, output int first_at);
        int c, r;
        c = 0; r = 0; nwr = 0; done_at = -1; first_at = -1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            wr_ready = bp ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
            @(negedge clk);
            while (c < 16 && !((mb + r < m_tot) && (nb + c < 64))) begin
                if (r == 15) begin r = 0; c++; end else r++;
            end
            if (o_done) begin
                done_at = cyc;
                check("rdy_in_done", o_rdy, 1);
                check("en_in_done", o_en, 0);
                check("all_written", c, 16);
                break;
            end
            check("rdy_in_drain", o_rdy, 0);
            if (o_en) begin
                if (first_at < 0) first_at = cyc;
                if (c >= 16) begin
                    check("extra_wr", 1, 0);
                end else begin
                    check("wr_addr", o_addr, (nb + c) * m_tot + mb + r);
                    check("wr_data", o_data, requant(tile_v[r][c], sh, rl));
                    if (wr_ready) begin
                        obs_addr[nwr] = int'(o_addr);
                        obs_data[nwr] = int'(o_data);
                        nwr++;
                        if (r == 15) begin r = 0; c++; end else r++;
                    end
                end
            end
            if (stop_after > 0 && nwr == stop_after) break;
            @(posedge clk); #1;
        end
        if (done_at < 0 && stop_after == 0) check("drain_timeout", 0, 1);
        wr_ready = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr, done_at, first_at;
        int vals [5];
        n_checks = 0; n_errors = 0;
        rv = 1'b0; sel_b = 1'b0; wr_ready = 1'b1; row_data = '0;
        row_m_base = '0; row_n_base = '0; cfg_shift = '0; cfg_relu = 1'b0;
        g_mb = 0; g_nb = 0; g_sh = 0; g_rl = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_b_wr_en", wr_en_b, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_row_ready", row_ready, 1);
        @(posedge clk); #1;

        // Identity tile: values above 127 saturate.
        fill_identity();
        g_mb = 0; g_nb = 0; g_sh = 0; g_rl = 1'b0;
        send_tile(0);
        drain(3136, 0, 0, 0, 1'b0, 1'b0, 0, nwr, done_at, first_at);
        check("id_nwr", nwr, 256);
        check("id_done_at", done_at, 257);
        check("id_first_at", first_at, 1);
        check("id_data5", obs_data[5], 5);
        check("id_data200", obs_data[200], 127);
        check("id_addr17", obs_addr[17], 3137);
        @(posedge clk); #1;

        // Requant corner with ReLU, shift 4.
        vals[0] = -100; vals[1] = 7; vals[2] = 8; vals[3] = 24; vals[4] = 100000;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                tile_v[r][c] = vals[(r + c) % 5];
        g_mb = 100; g_nb = 3; g_sh = 4; g_rl = 1'b1;
        send_tile(0);
        drain(3136, 100, 3, 4, 1'b1, 1'b0, 0, nwr, done_at, first_at);
        check("rq_nwr", nwr, 256);
        check("rq_d0", obs_data[0], 0);
        check("rq_d1", obs_data[1], 0);
        check("rq_d2", obs_data[2], 1);
        check("rq_d3", obs_data[3], 2);
        check("rq_d4", obs_data[4], 127);
        @(posedge clk); #1;

        // Shift 1 without ReLU: negative rounding and negative saturation.
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                tile_v[r][c] = (r - 8) * (c + 1) * 13;
        tile_v[0][0] = -1000; tile_v[1][0] = -3; tile_v[2][0] = 5; tile_v[3][0] = -4;
        g_mb = 7; g_nb = 20; g_sh = 1; g_rl = 1'b0;
        send_tile(0);
        drain(3136, 7, 20, 1, 1'b0, 1'b0, 0, nwr, done_at, first_at);
        check("neg_nwr", nwr, 256);
        check("neg_d0", obs_data[0], -128);
        check("neg_d1", obs_data[1], -1);
        check("neg_d2", obs_data[2], 3);
        check("neg_d3", obs_data[3], -2);
        @(posedge clk); #1;

        // Backpressure 1,0,0,1.
        fill_identity();
        g_mb = 0; g_nb = 0; g_sh = 0; g_rl = 1'b0;
        send_tile(0);
        drain(3136, 0, 0, 0, 1'b0, 1'b1, 0, nwr, done_at, first_at);
        check("bp_nwr", nwr, 256);
        check("bp_done_at", done_at, 513);
        check("bp_addr17", obs_addr[17], 3137);
        @(posedge clk); #1;

        // Boundary tile on the M_TOTAL=20 instance.
        sel_b = 1'b1;
        g_mb = 16; g_nb = 48; g_sh = 0; g_rl = 1'b0;
        send_tile(0);
        drain(20, 16, 48, 0, 1'b0, 1'b0, 0, nwr, done_at, first_at);
        check("bd_nwr", nwr, 64);
        check("bd_done_at", done_at, 257);
        check("bd_addr0", obs_addr[0], 976);
        check("bd_addr4", obs_addr[4], 996);
        check("bd_addr63", obs_addr[63], 1279);
        @(posedge clk); #1;
        sel_b = 1'b0;

        // Reset after write 37, then a fresh tile.
        g_mb = 0; g_nb = 0;
        send_tile(0);
        drain(3136, 0, 0, 0, 1'b0, 1'b0, 37, nwr, done_at, first_at);
        check("mr_nwr", nwr, 37);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mr_wr_en", wr_en, 0);
        check("mr_wr_addr", wr_addr, 0);
        check("mr_wr_data", wr_data, 0);
        @(negedge clk);
        check("mr_hold_en", wr_en, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_post_en", wr_en, 0);
        check("mr_post_rdy", row_ready, 1);
        check("mr_post_done", tile_done, 0);
        @(posedge clk); #1;
        g_mb = 32; g_nb = 16;
        send_tile(0);
        drain(3136, 32, 16, 0, 1'b0, 1'b0, 0, nwr, done_at, first_at);
        check("mr2_nwr", nwr, 256);
        check("mr2_done_at", done_at, 257);
        check("mr2_first_at", first_at, 1);
        @(posedge clk); #1;

        // Back-to-back: B's beat 0 waits on row_valid through A's drain.
        g_mb = 64; g_nb = 0;
        send_tile(0);
        g_mb = 128; g_nb = 32;
        drive_row(0);
        drain(3136, 64, 0, 0, 1'b0, 1'b0, 0, nwr, done_at, first_at);
        check("bb_a_nwr", nwr, 256);
        check("bb_a_done_at", done_at, 257);
        check("bb_valid_in_done", row_valid, 1);
        @(posedge clk); #1;
        send_tile(1);
        drain(3136, 128, 32, 0, 1'b0, 1'b0, 0, nwr, done_at, first_at);
        check("bb_b_nwr", nwr, 256);
        check("bb_b_done_at", done_at, 257);
        check("bb_b_addr0", obs_addr[0], 32 * 3136 + 128);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
